// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle-level event link receive path.
package toggle_pkg;

   localparam int SYNC_MIN = 2;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } dec_state_e;

endpackage

// File: rtl/toggle_sync.sv
// One toggle lane: metastability chain, previous-level flop and flip detect.
// While prime is high the previous level tracks the line so that a lane already
// high when reset releases does not look like an event.
module toggle_sync
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic t_in,
   input  logic prime,
   output logic edge_det
);

   localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // synchronizer chain and previous-level register, updated every cycle
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], t_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign edge_det = !prime && (sync_q[STAGES-1] ^ prev_q);

endmodule

// File: rtl/toggle_decoder.sv
// Toggle-level event decoder: turns lane flips into pulses, batches them into
// a valid/ready event word, and keeps per-lane saturating counts and overrun flags.
//
//   state | meaning
//   PRIME | chains settling after reset; prev tracks the line, no events
//   RUN   | flips decoded into pulses, words, counts and overruns
module toggle_decoder
   import toggle_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic                   _clock,
   input  logic                   _reset,
   input  logic [WIDTH-1:0]       _T,
   input  logic                   _E,
   output logic [WIDTH-1:0]       _P,
   output logic                   _valid,
   input  logic                   _ready,
   output logic [WIDTH-1:0]       _events,
   output logic [WIDTH-1:0]       _overrun,
   input  logic                   _clr_ovr,
   output logic [WIDTH*CNT_W-1:0] _count,
   input  logic                   _clr_cnt,
   output logic [WIDTH-1:0]       _return
);

   localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
   localparam int TMR_W  = $clog2(STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dec_state_e              state_q, state_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic                    prime;
   logic [WIDTH-1:0]        edges;
   logic [WIDTH-1:0]        ev;
   logic [WIDTH-1:0]        acc_q;
   logic [WIDTH-1:0]        pend;
   logic [WIDTH-1:0]        ovr_set;
   logic                    take;
   logic                    xfer;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q;

   // state register and prime down-counter
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         state_q <= PRIME;
         timer_q <= TMR_W'(STAGES);
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // leave PRIME once the prime counter reaches terminal count
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         PRIME: begin
            if (timer_q == '0) state_d = RUN;
            else               timer_d = timer_q - 1'b1;
         end
         RUN:     state_d = RUN;
         default: state_d = PRIME;
      endcase
   end

   assign prime = (state_q == PRIME);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      toggle_sync #(.SYNC_STAGES(STAGES)) u_sync (
         .clk_sys  (_clock),
         .rst_b    (_reset),
         .t_in     (_T[gi]),
         .prime    (prime),
         .edge_det (edges[gi])
      );
   end

   assign ev      = edges & {WIDTH{_E}};
   assign take    = _valid & _ready;
   assign pend    = acc_q | ev;
   assign xfer    = (!_valid || take) && (|pend);
   // a lane is overrun when it is already waiting in acc and will stay there
   assign ovr_set = ev & acc_q & {WIDTH{!xfer}};

   // pulse output and event-word handoff
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         _P      <= '0;
         _valid  <= 1'b0;
         _events <= '0;
         acc_q   <= '0;
      end else begin
         _P <= ev;
         if (xfer) begin
            _events <= pend;
            _valid  <= 1'b1;
            acc_q   <= '0;
         end else if (take) begin
            _valid  <= 1'b0;
            _events <= '0;
            acc_q   <= pend;
         end else begin
            acc_q   <= pend;
         end
      end
   end

   // sticky overrun flags; a new set beats a simultaneous clear
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) _overrun <= '0;
      else         _overrun <= (_overrun & {WIDTH{!_clr_ovr}}) | ovr_set;
   end

   // per-lane saturating event counters; clear with a same-cycle event gives 1
   always_ff @(posedge _clock or negedge _reset) begin
      if (!_reset) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (ev[i]) begin
               if (_clr_cnt)                cnt_q[i] <= CNT_W'(1);
               else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (_clr_cnt) begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign _count  = cnt_q;
   assign _return = _events;

endmodule

// File: tb/tb_toggle_decoder.sv
// Self-checking bench for toggle_decoder: random lane flips, ready, enable and
// clears against a lane-set reference model, with a word scoreboard.
module tb_toggle_decoder;

   localparam int W    = 4;
   localparam int SS   = 2;
   localparam int CW   = 2;
   localparam int LAT  = SS + 1;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk_sys = 1'b0;
   logic            rst_n;
   logic [W-1:0]    t_drv;
   logic            e_drv, ready_drv, clr_ovr, clr_cnt;
   logic [W-1:0]    p_o, events_o, ovr_o, ret_o;
   logic            valid_o;
   logic [W*CW-1:0] count_o;

   always #5 clk_sys = ~clk_sys;

   toggle_decoder #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
      ._clock   (clk_sys),
      ._reset   (rst_n),
      ._T       (t_drv),
      ._E       (e_drv),
      ._P       (p_o),
      ._valid   (valid_o),
      ._ready   (ready_drv),
      ._events  (events_o),
      ._overrun (ovr_o),
      ._clr_ovr (clr_ovr),
      ._count   (count_o),
      ._clr_cnt (clr_cnt),
      ._return  (ret_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a flip driven after clock edge n is seen as an event at
   // edge n+LAT, unless the lane is still priming or decode is disabled then.
   int           cyc;
   int           prime_left;
   logic [W-1:0] ring [8];
   int           m_cnt [W];
   logic [W-1:0] m_acc, m_events, m_ovr, m_p;
   bit           m_valid;
   logic [W-1:0] sb [$];

   function automatic void m_reset();
      cyc        = 0;
      prime_left = LAT;
      for (int k = 0; k < 8; k++) ring[k] = '0;
      for (int k = 0; k < W; k++) m_cnt[k] = 0;
      m_acc    = '0;
      m_events = '0;
      m_ovr    = '0;
      m_p      = '0;
      m_valid  = 1'b0;
      sb.delete();
   endfunction

   always @(posedge clk_sys) begin : model
      logic [W-1:0] due, ev, waiting;
      bit           take, send;
      if (!rst_n) begin
         m_reset();
      end else begin
         cyc++;
         due = ring[cyc % 8];
         ring[cyc % 8] = '0;
         if (prime_left > 0) begin
            prime_left--;
            ev = '0;
         end else begin
            ev = e_drv ? due : '0;
         end
         take    = m_valid && ready_drv;
         waiting = m_acc | ev;
         send    = (!m_valid || take) && (waiting != '0);
         m_ovr   = (clr_ovr ? '0 : m_ovr) | (send ? '0 : (ev & m_acc));
         for (int i = 0; i < W; i++) begin
            if (ev[i])        m_cnt[i] = clr_cnt ? 1 : ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX);
            else if (clr_cnt) m_cnt[i] = 0;
         end
         m_p = ev;
         if (send) begin
            m_events = waiting;
            m_valid  = 1'b1;
            m_acc    = '0;
            sb.push_back(waiting);
         end else if (take) begin
            m_valid  = 1'b0;
            m_events = '0;
            m_acc    = waiting;
         end else begin
            m_acc    = waiting;
         end
      end
   end

   // per-cycle output compare and scoreboard pop on each accepted word
   always @(negedge clk_sys) begin : monitor
      logic [W-1:0] exp_word;
      check("pulse", p_o, m_p);
      check("valid", valid_o, m_valid);
      check("events", events_o, m_events);
      check("return", ret_o, m_events);
      check("overrun", ovr_o, m_ovr);
      for (int i = 0; i < W; i++)
         check($sformatf("count%0d", i), count_o[i*CW +: CW], m_cnt[i]);
      if (rst_n && valid_o && ready_drv) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            check("sb_word", events_o, exp_word);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic flip(input logic [W-1:0] m);
      t_drv = t_drv ^ m;
      ring[(cyc + LAT) % 8] = ring[(cyc + LAT) % 8] | m;
   endtask

   task automatic rand_phase(input int n);
      for (int k = 0; k < n; k++) begin
         tick();
         ready_drv = 1'($urandom_range(0, 1));
         e_drv     = ($urandom_range(0, 7) != 0);
         clr_ovr   = ($urandom_range(0, 15) == 0);
         clr_cnt   = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 2) == 0) flip(W'($urandom_range(1, (1 << W) - 1)));
      end
      tick();
      clr_ovr = 1'b0;
      clr_cnt = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      t_drv     = 4'b0001;
      e_drv     = 1'b1;
      ready_drv = 1'b1;
      clr_ovr   = 1'b0;
      clr_cnt   = 1'b0;
      m_reset();

      // lane already high across reset release gives no event
      #22 rst_n = 1'b1;
      tick(8);
      @(negedge clk_sys);
      check("prime_no_pulse", p_o, 0);
      check("prime_no_valid", valid_o, 0);

      // single flip of lane 2 with consumer ready
      tick();
      flip(4'b0100);
      tick(LAT);
      @(negedge clk_sys);
      check("l2_pulse", p_o, 4'b0100);
      check("l2_valid", valid_o, 1);
      check("l2_events", events_o, 4'b0100);
      check("l2_count", count_o[2*CW +: CW], 1);

      // consumer stalled: lane 0 flips three times, third one overruns
      tick(3);
      ready_drv = 1'b0;
      flip(4'b0001);
      tick(4);
      flip(4'b0001);
      tick(4);
      flip(4'b0001);
      tick(LAT + 1);
      @(negedge clk_sys);
      check("ovr_set", ovr_o, 4'b0001);
      check("ovr_events_held", events_o, 4'b0001);
      check("ovr_valid_held", valid_o, 1);
      tick();
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      @(negedge clk_sys);
      check("ovr_cleared", ovr_o, 0);
      tick();
      ready_drv = 1'b1;
      tick(4);

      // lane 1 saturates, then clear together with a flip gives 1
      for (int k = 0; k < 5; k++) begin
         flip(4'b0010);
         tick(2);
      end
      tick(LAT);
      @(negedge clk_sys);
      check("sat_count", count_o[1*CW +: CW], CMAX);
      tick();
      flip(4'b0010);
      tick(LAT - 1);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      @(negedge clk_sys);
      check("clr_with_flip", count_o[1*CW +: CW], 1);

      // flip of lane 3 while disabled is dropped, including after re-enable
      tick(4);
      e_drv = 1'b0;
      flip(4'b1000);
      tick(6);
      e_drv = 1'b1;
      tick(4);
      @(negedge clk_sys);
      check("dis_count", count_o[3*CW +: CW], 0);
      check("dis_pulse", p_o, 0);
      check("dis_valid", valid_o, 0);

      rand_phase(500);

      // pending word dropped by a mid-cycle reset
      e_drv     = 1'b1;
      ready_drv = 1'b0;
      tick(2);
      flip(4'b0010);
      tick(LAT + 2);
      @(negedge clk_sys);
      check("pend_valid", valid_o, 1);
      @(posedge clk_sys);
      #3 rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_events", events_o, 0);
      check("rst_counts", count_o, 0);
      check("rst_overrun", ovr_o, 0);
      tick(2);
      #2 rst_n = 1'b1;
      tick(6);

      rand_phase(200);

      // drain everything still pending
      ready_drv = 1'b1;
      e_drv     = 1'b1;
      tick(12);
      @(negedge clk_sys);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
